// File: rtl/fdiv_pkg.sv
`default_nettype none
// fdiv_pkg: shared state encoding, datapath mux selects and operand classifiers
// for the Goldschmidt divide sequencer.

package fdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_N0   = 3'd1,
    ST_D0   = 3'd2,
    ST_IN   = 3'd3,
    ST_ID   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // B-mux selects
  localparam logic [1:0] SEL_NF = 2'd0;
  localparam logic [1:0] SEL_DF = 2'd1;
  localparam logic [1:0] SEL_RA = 2'd2;
  localparam logic [1:0] SEL_RB = 2'd3;

  // A-mux selects
  localparam logic SEL_IA = 1'b0;
  localparam logic SEL_RC = 1'b1;

  localparam int EXP_W = 10;

  // Classifiers take the magnitude field only; sign never matters here.
  function automatic logic is_zero(input logic [30:0] f);
    return f == 31'd0;
  endfunction

  function automatic logic is_inf(input logic [30:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [30:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fdiv_exp.sv
`default_nettype none
// fdiv_exp: captures quotient sign, biased exponent and special-operand flags
// on the accept cycle and holds them until the next accept.

module fdiv_exp
  import fdiv_pkg::*;
#(
  parameter int BIAS = 127
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [31:0]      n_i,
  input  logic [31:0]      d_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             dz_o,
  output logic             nan_o
);

  localparam logic [EXP_W-1:0] BIAS_C = EXP_W'(BIAS);

  logic             sign_d, sign_q;
  logic [EXP_W-1:0] exp_d, exp_q;
  logic             dz_d, dz_q;
  logic             nan_d, nan_q;

  logic n_zero, d_zero, n_inf, d_inf, n_nan, d_nan;

  always_comb begin
    n_zero = is_zero(n_i[30:0]);
    d_zero = is_zero(d_i[30:0]);
    n_inf  = is_inf(n_i[30:0]);
    d_inf  = is_inf(d_i[30:0]);
    n_nan  = is_nan(n_i[30:0]);
    d_nan  = is_nan(d_i[30:0]);

    sign_d = n_i[31] ^ d_i[31];
    // Two's-complement wrap is intentional; range handling happens downstream.
    exp_d  = {2'b00, n_i[30:23]} - {2'b00, d_i[30:23]} + BIAS_C;
    dz_d   = d_zero & ~n_zero;
    nan_d  = n_nan | d_nan | (n_zero & d_zero) | (n_inf & d_inf);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      dz_q   <= 1'b0;
      nan_q  <= 1'b0;
    end else if (en_i) begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      dz_q   <= dz_d;
      nan_q  <= nan_d;
    end
  end

  assign sign_o = sign_q;
  assign exp_o  = exp_q;
  assign dz_o   = dz_q;
  assign nan_o  = nan_q;

endmodule

`default_nettype wire

// File: rtl/fdiv_ctrl.sv
`default_nettype none
// fdiv_ctrl: sequences the Goldschmidt datapath through N0/D0 and ITERS
// refinement passes, then pulses done; all outputs decode from registered state.

module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      N,
  input  logic [31:0]      D,
  output logic             ready,
  output logic             op,
  output logic [1:0]       rm,
  output logic             ena,
  output logic             enb,
  output logic             enc,
  output logic             done,
  output logic             q_sign,
  output logic [EXP_W-1:0] q_exp,
  output logic             dz,
  output logic             nan
);

  localparam logic [2:0] LAST_CNT = 3'(ITERS - 1);

  state_e     state_d, state_q;
  logic [2:0] cnt_d, cnt_q;
  logic       accept;

  assign accept = start && (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    op      = SEL_IA;
    rm      = SEL_NF;
    ena     = 1'b0;
    enb     = 1'b0;
    enc     = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = ST_N0;
          cnt_d   = 3'd0;
        end
      end
      ST_N0: begin
        ena     = 1'b1;
        state_d = ST_D0;
      end
      ST_D0: begin
        rm      = SEL_DF;
        enb     = 1'b1;
        enc     = 1'b1;
        state_d = ST_IN;
      end
      ST_IN: begin
        op      = SEL_RC;
        rm      = SEL_RA;
        ena     = 1'b1;
        state_d = (cnt_q == LAST_CNT) ? ST_DONE : ST_ID;
      end
      ST_ID: begin
        op      = SEL_RC;
        rm      = SEL_RB;
        enb     = 1'b1;
        enc     = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        state_d = ST_IN;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fdiv_exp #(
    .BIAS(BIAS)
  ) u_exp (
    .clk    (clk),
    .rst_ni (reset),
    .en_i   (accept),
    .n_i    (N),
    .d_i    (D),
    .sign_o (q_sign),
    .exp_o  (q_exp),
    .dz_o   (dz),
    .nan_o  (nan)
  );

endmodule

`default_nettype wire

// File: tb/tb_fdiv_ctrl.sv
`default_nettype none
// tb_fdiv_ctrl: directed vectors for the divide sequencer (ITERS=3 and ITERS=1).

module tb_fdiv_ctrl;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] N      = 32'd0;
  logic [31:0] D      = 32'd0;

  logic       ready3, op3, ena3, enb3, enc3, done3, q_sign3, dz3, nan3;
  logic [1:0] rm3;
  logic [9:0] q_exp3;
  logic       ready1, op1, ena1, enb1, enc1, done1, q_sign1, dz1, nan1;
  logic [1:0] rm1;
  logic [9:0] q_exp1;

  int n_tests = 0;
  int n_fail  = 0;

  // {op, rm, ena, enb, enc, done, ready}
  localparam logic [7:0] C_IDLE = 8'h01;
  localparam logic [7:0] C_N0   = 8'h10;
  localparam logic [7:0] C_D0   = 8'h2C;
  localparam logic [7:0] C_IN   = 8'hD0;
  localparam logic [7:0] C_ID   = 8'hEC;
  localparam logic [7:0] C_DONE = 8'h02;

  logic [7:0] ctrl3, ctrl1;
  assign ctrl3 = {op3, rm3, ena3, enb3, enc3, done3, ready3};
  assign ctrl1 = {op1, rm1, ena1, enb1, enc1, done1, ready1};

  logic [7:0] seq3 [9];
  logic [7:0] seq1 [5];

  fdiv_ctrl #(.ITERS(3), .BIAS(127)) dut3 (
    .clk(clk), .reset(reset), .start(start), .N(N), .D(D),
    .ready(ready3), .op(op3), .rm(rm3), .ena(ena3), .enb(enb3), .enc(enc3),
    .done(done3), .q_sign(q_sign3), .q_exp(q_exp3), .dz(dz3), .nan(nan3)
  );

  fdiv_ctrl #(.ITERS(1), .BIAS(127)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .N(N), .D(D),
    .ready(ready1), .op(op1), .rm(rm1), .ena(ena1), .enb(enb1), .enc(enc1),
    .done(done1), .q_sign(q_sign1), .q_exp(q_exp1), .dz(dz1), .nan(nan1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one divide on dut3, walk the full schedule, then check captured results.
  task automatic run_div(input string tag, input logic [31:0] n, input logic [31:0] d,
                         input logic sgn, input logic [9:0] ex, input logic ez, input logic en);
    N = n;
    D = d;
    start = 1'b1;
    step();
    start = 1'b0;
    N = 32'h7FC00001;
    D = 32'h00000000;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("%s seq%0d", tag, i), {24'd0, ctrl3}, {24'd0, seq3[i]});
      if (i < 8) step();
    end
    check({tag, " sign"}, {31'd0, q_sign3}, {31'd0, sgn});
    check({tag, " exp"},  {22'd0, q_exp3},  {22'd0, ex});
    check({tag, " dz"},   {31'd0, dz3},     {31'd0, ez});
    check({tag, " nan"},  {31'd0, nan3},    {31'd0, en});
  endtask

  initial begin
    seq3 = '{C_N0, C_D0, C_IN, C_ID, C_IN, C_ID, C_IN, C_DONE, C_IDLE};
    seq1 = '{C_N0, C_D0, C_IN, C_DONE, C_IDLE};

    #1 reset = 1'b0;
    #2;
    check("rst ctrl", {24'd0, ctrl3}, {24'd0, C_IDLE});
    check("rst exp",  {22'd0, q_exp3}, 32'd0);
    check("rst flags", {29'd0, q_sign3, dz3, nan3}, 32'd0);
    #4 reset = 1'b1;

    run_div("div6_2",  32'h40C00000, 32'h40000000, 1'b0, 10'd128,  1'b0, 1'b0);
    run_div("neg",     32'hC0400000, 32'h3F800000, 1'b1, 10'd128,  1'b0, 1'b0);
    run_div("uflow",   32'h00800000, 32'h7F000000, 1'b0, 10'h382,  1'b0, 1'b0);
    run_div("divzero", 32'h3F800000, 32'h00000000, 1'b0, 10'd254,  1'b1, 1'b0);
    run_div("zz",      32'h00000000, 32'h00000000, 1'b0, 10'd127,  1'b0, 1'b1);
    run_div("infinf",  32'h7F800000, 32'hFF800000, 1'b1, 10'd127,  1'b0, 1'b1);
    run_div("nanop",   32'h7FC00000, 32'h3F800000, 1'b0, 10'd255,  1'b0, 1'b1);

    // start pulsed during ID must be ignored
    N = 32'h40C00000; D = 32'h40000000; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    check("ign in_id", {24'd0, ctrl3}, {24'd0, C_ID});
    N = 32'h00800000; D = 32'h7F000000; start = 1'b1;
    step();
    start = 1'b0;
    check("ign next", {24'd0, ctrl3}, {24'd0, C_IN});
    check("ign exp",  {22'd0, q_exp3}, 32'd128);
    step(); step(); step();
    check("ign done", {24'd0, ctrl3}, {24'd0, C_DONE});
    step();
    check("ign idle", {24'd0, ctrl3}, {24'd0, C_IDLE});
    check("ign exp2", {22'd0, q_exp3}, 32'd128);

    // start held high: second accept on the IDLE cycle right after DONE
    N = 32'h40C00000; D = 32'h40000000; start = 1'b1;
    step();
    check("b2b n0a", {24'd0, ctrl3}, {24'd0, C_N0});
    for (int i = 0; i < 7; i++) step();
    check("b2b done", {24'd0, ctrl3}, {24'd0, C_DONE});
    step();
    check("b2b idle", {24'd0, ctrl3}, {24'd0, C_IDLE});
    step();
    check("b2b n0b", {24'd0, ctrl3}, {24'd0, C_N0});
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("b2b end", {24'd0, ctrl3}, {24'd0, C_IDLE});

    // asynchronous reset during the second IN
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    check("mrst in2", {24'd0, ctrl3}, {24'd0, C_IN});
    reset = 1'b0;
    #1;
    check("mrst ctrl", {24'd0, ctrl3}, {24'd0, C_IDLE});
    check("mrst exp",  {22'd0, q_exp3}, 32'd0);
    #1 reset = 1'b1;
    step();
    check("mrst hold", {24'd0, ctrl3}, {24'd0, C_IDLE});

    // ITERS=1: N0 D0 IN DONE
    N = 32'h40C00000; D = 32'h40000000; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("it1 seq%0d", i), {24'd0, ctrl1}, {24'd0, seq1[i]});
      if (i < 4) step();
    end
    check("it1 exp", {22'd0, q_exp1}, 32'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
